// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with XOR accumulator, result flags and a
// transaction counter behind a valid/ready handshake.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             accept;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc_next;

  // Operation decode; acc_next only differs from acc_q for the accumulator ops.
  always_comb begin
    result   = '0;
    acc_next = acc_q;
    case (op)
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_XOR:     result = a ^ b;
      OP_NAND:    result = ~(a & b);
      OP_NOR:     result = ~(a | b);
      OP_XNOR:    result = ~(a ^ b);
      OP_ACC_XOR: begin
        result   = acc_q ^ a ^ b;
        acc_next = acc_q ^ a ^ b;
      end
      OP_ACC_CLR: begin
        result   = acc_q;
        acc_next = '0;
      end
      default:    result = '0;
    endcase
  end

  // Handshake and next-state; a simultaneous drain and accept keeps out_valid high.
  always_comb begin
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;

    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;

    if (accept) begin
      y_d         = result;
      zero_d      = (result == '0);
      parity_d    = ^result;
      out_valid_d = 1'b1;
      acc_d       = acc_next;
      op_count_d  = op_count_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe against a queue-free
// transaction-level model (32-bit instance) plus a small 8-bit/2-bit-counter instance.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        zero;
  logic        parity;
  logic [31:0] acc;
  logic [15:0] op_count;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [2:0]  s_op;
  logic [7:0]  s_a;
  logic [7:0]  s_b;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_y;
  logic        s_zero;
  logic        s_parity;
  logic [7:0]  s_acc;
  logic [1:0]  s_op_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_y;
  logic [31:0] m_acc;
  int          m_cnt;

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .parity(parity), .acc(acc), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y),
    .zero(s_zero), .parity(s_parity), .acc(s_acc), .op_count(s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] av,
                                             input logic [31:0] bv, input logic [31:0] ac);
    case (o)
      3'd0:    return av & bv;
      3'd1:    return av | bv;
      3'd2:    return av ^ bv;
      3'd3:    return ~(av & bv);
      3'd4:    return ~(av | bv);
      3'd5:    return ~(av ^ bv);
      3'd6:    return ac ^ av ^ bv;
      default: return ac;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".y"},         y, m_y);
    check({tag, ".zero"},      32'(zero), 32'(m_y == 32'd0));
    check({tag, ".parity"},    32'(parity), 32'($countones(m_y) % 2));
    check({tag, ".acc"},       acc, m_acc);
    check({tag, ".op_count"},  32'(op_count), 32'(m_cnt % 65536));
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = 32'd0;
    m_acc   = 32'd0;
    m_cnt   = 0;
  endtask

  // One cycle: drive at negedge, check in_ready, clock, update model, check at next negedge.
  task automatic step(input string tag, input logic iv, input logic [2:0] o,
                      input logic [31:0] av, input logic [31:0] bv, input logic ordy);
    logic exp_ready;
    logic take;
    in_valid  = iv;
    op        = o;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    exp_ready = !m_valid || ordy;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    take = iv && exp_ready;
    @(posedge clk);
    if (take) begin
      m_y     = ref_result(o, av, bv, m_acc);
      if (o == 3'd6) m_acc = m_y;
      if (o == 3'd7) m_acc = 32'd0;
      m_valid = 1'b1;
      m_cnt++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic s_step(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    s_in_valid  = 1'b1;
    s_op        = o;
    s_a         = av;
    s_b         = bv;
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // XOR directed
    step("xor", 1'b1, 3'd2, 32'h1234_5678, 32'hABCD_EF01, 1'b1);
    check("xor.y_const", y, 32'hB9F9_B979);
    check("xor.parity_const", 32'(parity), 32'd1);
    check("xor.cnt_const", 32'(op_count), 32'd1);

    // NAND all-ones then drain
    step("nand", 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("nand.zero_const", 32'(zero), 32'd1);
    step("drain", 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h1, 1'b1);
    check("drain.valid_const", 32'(out_valid), 32'd0);

    // Backpressure
    step("bp_or", 1'b1, 3'd1, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("bp_stall", 1'b1, 3'd0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
      check("bp_stall.y_const", y, 32'hFFFF_0000);
    end
    step("bp_release", 1'b1, 3'd0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1);
    check("bp_release.y_const", y, 32'h0F0F_0F0F);
    check("bp_release.valid_const", 32'(out_valid), 32'd1);

    // Accumulate
    step("acc1", 1'b1, 3'd6, 32'h0000_00FF, 32'h0, 1'b1);
    check("acc1.acc_const", acc, 32'h0000_00FF);
    step("acc2", 1'b1, 3'd6, 32'h0000_0F00, 32'h0, 1'b1);
    check("acc2.y_const", y, 32'h0000_0FFF);
    step("acc_clr", 1'b1, 3'd7, 32'h1234, 32'h5678, 1'b1);
    check("acc_clr.y_const", y, 32'h0000_0FFF);
    check("acc_clr.acc_const", acc, 32'h0);
    step("acc3", 1'b1, 3'd6, 32'h0, 32'h0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom),
           32'($urandom), 32'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Mid-stream reset between clock edges
    step("pre_rst", 1'b1, 3'd6, 32'h0000_0FFF, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 3'd2, 32'hA5A5_A5A5, 32'h5A5A_0000, 1'b1);
    check("post_rst.cnt_const", 32'(op_count), 32'd1);
    step("idle", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    // Narrow instance: XNOR to zero and counter wrap
    s_step(3'd5, 8'hAA, 8'h55);
    check("small.y", 32'(s_y), 32'h0);
    check("small.zero", 32'(s_zero), 32'd1);
    check("small.valid", 32'(s_out_valid), 32'd1);
    check("small.cnt1", 32'(s_op_count), 32'd1);
    for (int i = 0; i < 4; i++) s_step(3'd0, 8'h3C, 8'hF0);
    check("small.y_and", 32'(s_y), 32'h30);
    check("small.in_ready", 32'(s_in_ready), 32'd1);
    check("small.cnt_wrap", 32'(s_op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
